// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX pipeline boundary signals between decode and execute.
interface id_ex_stage_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               id_valid;
  logic [XLEN-1:0]    id_pc;
  logic [RADDR_W-1:0] id_rs1, id_rs2, id_rd;
  logic               id_uses_rs1, id_uses_rs2;
  logic [XLEN-1:0]    id_rs1_data, id_rs2_data, id_imm;
  logic [3:0]         id_alu_op;
  logic [2:0]         id_funct3;
  logic               id_alu_src, id_mem_read, id_mem_write, id_reg_write;
  logic               id_mem_to_reg, id_branch, id_jump;
  logic               flush_ex;

  logic               ex_valid;
  logic [XLEN-1:0]    ex_pc;
  logic [RADDR_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0]    ex_rs1_data, ex_rs2_data, ex_imm;
  logic [3:0]         ex_alu_op;
  logic [2:0]         ex_funct3;
  logic               ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
  logic               ex_mem_to_reg, ex_branch, ex_jump;
  logic               stall_if_id;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_alu_op, id_funct3,
           id_alu_src, id_mem_read, id_mem_write, id_reg_write,
           id_mem_to_reg, id_branch, id_jump, flush_ex,
    input  ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_alu_op, ex_funct3, ex_alu_src, ex_mem_read,
           ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump,
           stall_if_id
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_alu_op, id_funct3,
           id_alu_src, id_mem_read, id_mem_write, id_reg_write,
           id_mem_to_reg, id_branch, id_jump, flush_ex,
    output ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_alu_op, ex_funct3, ex_alu_src, ex_mem_read,
           ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump,
           stall_if_id
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall, flush and perf counters.
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  id_ex_stage_if.slave      bus,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  logic rs1_match, rs2_match, hazard;

  assign rs1_match = bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd);
  assign rs2_match = bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd);
  assign hazard    = bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != '0) &
                     (rs1_match | rs2_match) & bus.id_valid;
  // A flushed ID instruction is dead, so it must never hold the front end.
  assign bus.stall_if_id = hazard & ~bus.flush_ex;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ex_valid      <= 1'b0;
      bus.ex_pc         <= '0;
      bus.ex_rs1        <= '0;
      bus.ex_rs2        <= '0;
      bus.ex_rd         <= '0;
      bus.ex_rs1_data   <= '0;
      bus.ex_rs2_data   <= '0;
      bus.ex_imm        <= '0;
      bus.ex_alu_op     <= '0;
      bus.ex_funct3     <= '0;
      bus.ex_alu_src    <= 1'b0;
      bus.ex_mem_read   <= 1'b0;
      bus.ex_mem_write  <= 1'b0;
      bus.ex_reg_write  <= 1'b0;
      bus.ex_mem_to_reg <= 1'b0;
      bus.ex_branch     <= 1'b0;
      bus.ex_jump       <= 1'b0;
      stall_count       <= '0;
      flush_count       <= '0;
    end else if (bus.flush_ex || hazard) begin
      bus.ex_valid      <= 1'b0;
      bus.ex_pc         <= '0;
      bus.ex_rs1        <= '0;
      bus.ex_rs2        <= '0;
      bus.ex_rd         <= '0;
      bus.ex_rs1_data   <= '0;
      bus.ex_rs2_data   <= '0;
      bus.ex_imm        <= '0;
      bus.ex_alu_op     <= '0;
      bus.ex_funct3     <= '0;
      bus.ex_alu_src    <= 1'b0;
      bus.ex_mem_read   <= 1'b0;
      bus.ex_mem_write  <= 1'b0;
      bus.ex_reg_write  <= 1'b0;
      bus.ex_mem_to_reg <= 1'b0;
      bus.ex_branch     <= 1'b0;
      bus.ex_jump       <= 1'b0;
      // Flush takes the credit when both fire; the stall is moot then.
      if (bus.flush_ex) begin
        if (flush_count != '1) flush_count <= flush_count + CNT_W'(1);
      end else begin
        if (stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      end
    end else begin
      bus.ex_valid      <= bus.id_valid;
      bus.ex_pc         <= bus.id_pc;
      bus.ex_rs1        <= bus.id_rs1;
      bus.ex_rs2        <= bus.id_rs2;
      bus.ex_rd         <= bus.id_rd;
      bus.ex_rs1_data   <= bus.id_rs1_data;
      bus.ex_rs2_data   <= bus.id_rs2_data;
      bus.ex_imm        <= bus.id_imm;
      bus.ex_alu_op     <= bus.id_alu_op;
      bus.ex_funct3     <= bus.id_funct3;
      bus.ex_alu_src    <= bus.id_alu_src;
      bus.ex_mem_read   <= bus.id_mem_read;
      bus.ex_mem_write  <= bus.id_mem_write;
      bus.ex_reg_write  <= bus.id_reg_write;
      bus.ex_mem_to_reg <= bus.id_mem_to_reg;
      bus.ex_branch     <= bus.id_branch;
      bus.ex_jump       <= bus.id_jump;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized bench for id_ex_stage against an instruction-level model.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int RADDR_W = 5;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [3:0]  alu_op;
    logic [2:0]  funct3;
    logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump;
  } instr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CNT_W-1:0] stall_count, flush_count;

  id_ex_stage_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) bus ();

  id_ex_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: what EX holds, the two counters, and the instruction in ID.
  instr_t m_ex;
  int     m_stalls, m_flushes;
  instr_t id_i;
  logic   id_u1, id_u2, id_flush;
  logic   last_stall;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic instr_t dut_ex();
    instr_t r;
    r.valid = bus.ex_valid;       r.pc = bus.ex_pc;
    r.rs1 = bus.ex_rs1;           r.rs2 = bus.ex_rs2;           r.rd = bus.ex_rd;
    r.rs1_data = bus.ex_rs1_data; r.rs2_data = bus.ex_rs2_data; r.imm = bus.ex_imm;
    r.alu_op = bus.ex_alu_op;     r.funct3 = bus.ex_funct3;     r.alu_src = bus.ex_alu_src;
    r.mem_read = bus.ex_mem_read; r.mem_write = bus.ex_mem_write;
    r.reg_write = bus.ex_reg_write; r.mem_to_reg = bus.ex_mem_to_reg;
    r.branch = bus.ex_branch;     r.jump = bus.ex_jump;
    return r;
  endfunction

  task automatic drive();
    bus.id_valid = id_i.valid;       bus.id_pc = id_i.pc;
    bus.id_rs1 = id_i.rs1;           bus.id_rs2 = id_i.rs2;         bus.id_rd = id_i.rd;
    bus.id_rs1_data = id_i.rs1_data; bus.id_rs2_data = id_i.rs2_data; bus.id_imm = id_i.imm;
    bus.id_alu_op = id_i.alu_op;     bus.id_funct3 = id_i.funct3;   bus.id_alu_src = id_i.alu_src;
    bus.id_mem_read = id_i.mem_read; bus.id_mem_write = id_i.mem_write;
    bus.id_reg_write = id_i.reg_write; bus.id_mem_to_reg = id_i.mem_to_reg;
    bus.id_branch = id_i.branch;     bus.id_jump = id_i.jump;
    bus.id_uses_rs1 = id_u1;         bus.id_uses_rs2 = id_u2;
    bus.flush_ex = id_flush;
  endtask

  // A load in EX whose destination the ID instruction reads forces one bubble.
  function automatic logic model_load_use();
    logic reads_it;
    reads_it = (id_u1 && id_i.rs1 == m_ex.rd) || (id_u2 && id_i.rs2 == m_ex.rd);
    return m_ex.valid && m_ex.mem_read && m_ex.rd != 0 && reads_it && id_i.valid;
  endfunction

  task automatic step(input string tag);
    logic exp_stall;
    drive();
    #1;
    exp_stall = model_load_use() && !id_flush;
    check({tag, "_stall"}, 192'(bus.stall_if_id), 192'(exp_stall));
    @(posedge clk);
    if (id_flush) begin
      m_ex = '0;
      if (m_flushes < int'(CMAX)) m_flushes++;
    end else if (model_load_use()) begin
      m_ex = '0;
      if (m_stalls < int'(CMAX)) m_stalls++;
    end else begin
      m_ex = id_i;
    end
    last_stall = exp_stall;
    @(negedge clk);
    check({tag, "_ex"}, 192'(dut_ex()), 192'(m_ex));
    check({tag, "_scnt"}, 192'(stall_count), 192'(m_stalls));
    check({tag, "_fcnt"}, 192'(flush_count), 192'(m_flushes));
  endtask

  function automatic instr_t rand_instr();
    instr_t r;
    r.valid = ($urandom_range(0, 7) != 0);
    r.pc = $urandom & 32'hFFFF_FFFC;
    r.rs1 = 5'($urandom_range(0, 3)); r.rs2 = 5'($urandom_range(0, 3));
    r.rd = 5'($urandom_range(0, 3));
    r.rs1_data = $urandom; r.rs2_data = $urandom; r.imm = $urandom;
    r.alu_op = 4'($urandom); r.funct3 = 3'($urandom);
    r.alu_src = 1'($urandom); r.mem_read = ($urandom_range(0, 2) == 0);
    r.mem_write = 1'($urandom); r.reg_write = 1'($urandom);
    r.mem_to_reg = 1'($urandom); r.branch = 1'($urandom); r.jump = 1'($urandom);
    return r;
  endfunction

  function automatic instr_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic mem_read);
    instr_t r = '0;
    r.valid = 1'b1; r.pc = pc; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.mem_read = mem_read; r.mem_to_reg = mem_read; r.reg_write = 1'b1;
    r.rs1_data = 32'h1111_0000 + 32'(rs1); r.imm = 32'h4;
    return r;
  endfunction

  initial begin
    m_ex = '0; m_stalls = 0; m_flushes = 0;
    id_i = '0; id_u1 = 0; id_u2 = 0; id_flush = 0; last_stall = 0;
    drive();
    #12;
    check("reset_ex", 192'(dut_ex()), 192'(0));
    check("reset_stall", 192'(bus.stall_if_id), 192'(0));
    check("reset_cnt", 192'({stall_count, flush_count}), 192'(0));
    @(negedge clk);
    rst = 1'b0;

    id_i = '0; id_i.valid = 1; id_i.pc = 32'h100; id_i.rs1_data = 32'hDEAD_BEEF;
    id_i.imm = 32'hFFFF_FFF0; id_i.reg_write = 1; id_i.rd = 5;
    step("capture");
    check("capture_pc", 192'(bus.ex_pc), 192'(32'h100));
    check("capture_data", 192'({bus.ex_rs1_data, bus.ex_imm}), 192'({32'hDEAD_BEEF, 32'hFFFF_FFF0}));
    check("capture_rdv", 192'({bus.ex_rd, bus.ex_valid}), 192'({5'd5, 1'b1}));

    id_i = mk(32'h104, 5, 2, 0, 1); id_u1 = 1; id_u2 = 0; step("lw_x5");
    id_i = mk(32'h108, 6, 5, 1, 0); id_u1 = 1; id_u2 = 1; step("lu_stall");
    check("lu_stall_seen", 192'(last_stall), 192'(1));
    step("lu_retry");
    check("lu_ex_rd", 192'(bus.ex_rd), 192'(6));
    check("lu_count", 192'(stall_count), 192'(1));

    id_i = mk(32'h10C, 0, 1, 0, 1); id_u1 = 1; id_u2 = 0; step("lw_x0");
    id_i = mk(32'h110, 7, 0, 0, 0); id_u1 = 1; id_u2 = 1; step("x0_nohz");
    id_i = mk(32'h114, 5, 1, 0, 1); id_u1 = 1; id_u2 = 0; step("lw_x5b");
    id_i = mk(32'h118, 5, 5, 5, 0); id_u1 = 0; id_u2 = 0; step("lui_nohz");

    id_i = mk(32'h11C, 5, 1, 0, 1); id_u1 = 1; id_u2 = 0; step("lw_x5c");
    id_i = mk(32'h120, 6, 5, 0, 0); id_u1 = 1; id_flush = 1; step("flush_lu");
    id_flush = 0;
    check("flush_cnt", 192'({stall_count, flush_count}), 192'({4'd1, 4'd1}));

    // Asynchronous reset taken in the middle of the high phase.
    id_i = mk(32'h124, 7, 1, 0, 1); id_u1 = 1; step("pre_rst");
    id_i = mk(32'h128, 8, 7, 0, 0); drive();
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check("midrst_ex", 192'(dut_ex()), 192'(0));
    check("midrst_stall", 192'(bus.stall_if_id), 192'(0));
    check("midrst_cnt", 192'({stall_count, flush_count}), 192'(0));
    m_ex = '0; m_stalls = 0; m_flushes = 0;
    @(negedge clk); rst = 1'b0;
    step("post_rst");

    for (int i = 0; i < 300; i++) begin
      if (!last_stall) begin
        id_i = rand_instr();
        id_u1 = 1'($urandom); id_u2 = 1'($urandom);
      end
      id_flush = ($urandom_range(0, 7) == 0);
      step($sformatf("rnd%0d", i));
    end
    id_flush = 0;

    for (int i = 0; i < 18; i++) begin
      id_i = mk(32'h200, 9, 1, 0, 1); id_u1 = 1; id_u2 = 0; step("sat_lw");
      id_i = mk(32'h204, 10, 9, 0, 0); step("sat_use");
      step("sat_retry");
    end
    check("sat_stall", 192'(stall_count), 192'(CMAX));

    for (int i = 0; i < 18; i++) begin
      id_i = rand_instr(); id_flush = 1; step("sat_flush");
    end
    id_flush = 0;
    check("sat_flushcnt", 192'(flush_count), 192'(CMAX));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
